// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with valid/ready issue, branch/jump resolution
// and an optional bit-serial shifter. Result, writeback and redirect outputs are registered.
module alu_mc #(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [3:0]      op,
  input  logic            unsign,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            imm_valid,
  input  logic [XLEN-1:0] instr_tag,
  input  logic [4:0]      rd_addr,
  input  logic            rd_wr,
  output logic            out_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_rd_wr_en,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_load,
  output logic            misalign
);
  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_BLT  = 4'd11;
  localparam logic [3:0] OP_BGE  = 4'd12;
  localparam logic [3:0] OP_JAL  = 4'd13;
  localparam logic [3:0] OP_JALR = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
  state_t state, state_nxt;

  // Combinational evaluation of the op presented on the issue port
  logic            is_branch, is_jump, is_shift, is_sub, start_serial;
  logic [XLEN-1:0] opb, add_b, sum, result, target, link;
  logic            cout, ovf, lt, eq, taken, wr_ok;
  logic [SW-1:0]   shamt;

  always_comb begin
    is_branch = op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
    is_jump   = (op == OP_JAL) || (op == OP_JALR);
    is_shift  = op inside {OP_SLL, OP_SRL, OP_SRA};
    is_sub    = (op == OP_SUB) || (op == OP_SLT) || is_branch;
    opb       = (imm_valid && !is_branch) ? imm : rs2_data;
    add_b     = is_sub ? ~opb : opb;
    {cout, sum} = {1'b0, rs1_data} + {1'b0, add_b} + (XLEN+1)'(is_sub);
    // Two's-complement overflow of a + add_b decides the signed compare
    ovf       = (rs1_data[XLEN-1] == add_b[XLEN-1]) && (sum[XLEN-1] != rs1_data[XLEN-1]);
    lt        = unsign ? ~cout : (sum[XLEN-1] ^ ovf);
    eq        = (rs1_data == rs2_data);
    shamt     = opb[SW-1:0];
    link      = instr_tag + XLEN'(4);
    target    = (op == OP_JALR) ? ((rs1_data + imm) & ~XLEN'(1)) : (instr_tag + imm);
    wr_ok     = rd_wr && (rd_addr != 5'd0) && !is_branch && (op != OP_NOP);
    start_serial = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);

    result = '0;
    taken  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: result = sum;
      OP_AND:  result = rs1_data & opb;
      OP_OR:   result = rs1_data | opb;
      OP_XOR:  result = rs1_data ^ opb;
      OP_SLL:  result = rs1_data << shamt;
      OP_SRL:  result = rs1_data >> shamt;
      OP_SRA:  result = $signed(rs1_data) >>> shamt;
      OP_SLT:  result = XLEN'(lt);
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = ~eq;
      OP_BLT:  taken = lt;
      OP_BGE:  taken = ~lt;
      OP_JAL, OP_JALR: begin
        result = link;
        taken  = 1'b1;
      end
      default: result = '0;
    endcase
  end

  // Serial shifter state
  logic [XLEN-1:0] sh_q, sh_step;
  logic [SW-1:0]   cnt_q;
  logic [1:0]      sh_kind;
  logic [4:0]      sh_rd;
  logic            sh_wr;

  always_comb begin
    case (sh_kind)
      2'b01:   sh_step = {sh_q[XLEN-2:0], 1'b0};
      2'b10:   sh_step = {1'b0, sh_q[XLEN-1:1]};
      default: sh_step = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
    endcase
  end

  // Handshake: an op transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, outside reset and when flush is low.
  logic accept, fire_single, fire_start, fire_final;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fire_start) state_nxt = S_SHIFT;
      S_SHIFT: if (flush || (cnt_q == SW'(1))) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = !rst && (state == S_IDLE) && !flush;
    accept      = in_valid && in_ready;
    fire_single = accept && !start_serial;
    fire_start  = accept && start_serial;
    fire_final  = (state == S_SHIFT) && (cnt_q == SW'(1)) && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      wb_data     <= '0;
      wb_rd_addr  <= '0;
      wb_rd_wr_en <= 1'b0;
      pc_out      <= '0;
      pc_load     <= 1'b0;
      misalign    <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      sh_kind     <= '0;
      sh_rd       <= '0;
      sh_wr       <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      wb_rd_wr_en <= 1'b0;
      if (fire_single) begin
        out_valid   <= 1'b1;
        wb_data     <= result;
        wb_rd_addr  <= rd_addr;
        wb_rd_wr_en <= wr_ok;
        pc_load     <= taken & ~target[1];
        misalign    <= taken & target[1];
        if (is_branch || is_jump) pc_out <= target;
      end
      if (fire_start) begin
        sh_q    <= rs1_data;
        cnt_q   <= shamt;
        sh_kind <= op[1:0];
        sh_rd   <= rd_addr;
        sh_wr   <= wr_ok;
      end
      if (state == S_SHIFT) begin
        sh_q  <= sh_step;
        cnt_q <= cnt_q - SW'(1);
      end
      if (fire_final) begin
        out_valid   <= 1'b1;
        wb_data     <= sh_step;
        wb_rd_addr  <= sh_rd;
        wb_rd_wr_en <= sh_wr;
        pc_load     <= 1'b0;
        misalign    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit serial-shift instance and a 64-bit barrel instance,
// directed scenarios plus random ops checked against an arithmetic reference model.
module tb_alu_mc;
  logic        clk, rst, flush, v32, v64, unsign, iv, rd_wr;
  logic [3:0]  op;
  logic [63:0] rs1, rs2, imm, tag;
  logic [4:0]  rd;

  logic        rdy32, ov32, wr32, ld32, mis32;
  logic [31:0] wb32, pc32;
  logic [4:0]  wbrd32;
  logic        rdy64, ov64, wr64, ld64, mis64;
  logic [63:0] wb64, pc64;
  logic [4:0]  wbrd64;

  int n_chk = 0;
  int n_err = 0;

  logic        g_rdy, g_ov, g_wr, g_ld, g_mis;
  logic [63:0] g_wb, g_pc;
  logic [4:0]  g_rd;

  alu_mc #(.XLEN(32), .SERIAL_SHIFT(1)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .flush(flush), .op(op),
    .unsign(unsign), .rs1_data(rs1[31:0]), .rs2_data(rs2[31:0]), .imm(imm[31:0]),
    .imm_valid(iv), .instr_tag(tag[31:0]), .rd_addr(rd), .rd_wr(rd_wr),
    .out_valid(ov32), .wb_data(wb32), .wb_rd_addr(wbrd32), .wb_rd_wr_en(wr32),
    .pc_out(pc32), .pc_load(ld32), .misalign(mis32)
  );

  alu_mc #(.XLEN(64), .SERIAL_SHIFT(0)) u64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .flush(flush), .op(op),
    .unsign(unsign), .rs1_data(rs1), .rs2_data(rs2), .imm(imm),
    .imm_valid(iv), .instr_tag(tag), .rd_addr(rd), .rd_wr(rd_wr),
    .out_valid(ov64), .wb_data(wb64), .wb_rd_addr(wbrd64), .wb_rd_wr_en(wr64),
    .pc_out(pc64), .pc_load(ld64), .misalign(mis64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic grab(input bit w64);
    if (w64) begin
      g_rdy = rdy64; g_ov = ov64; g_wb = wb64; g_rd = wbrd64;
      g_wr = wr64; g_pc = pc64; g_ld = ld64; g_mis = mis64;
    end else begin
      g_rdy = rdy32; g_ov = ov32; g_wb = {32'b0, wb32}; g_rd = wbrd32;
      g_wr = wr32; g_pc = {32'b0, pc32}; g_ld = ld32; g_mis = mis32;
    end
  endtask

  function automatic logic [63:0] sx(input int xl, input logic [63:0] v);
    return (xl == 32) ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // Reference: plain arithmetic on 64-bit values, truncated to the datapath width
  function automatic void model(input int xl, input logic [3:0] o, input logic u,
      input logic [63:0] a_in, input logic [63:0] rs2_in, input logic [63:0] imm_in,
      input logic ivl, input logic [63:0] tag_in, input logic [4:0] r, input logic rw,
      output logic [63:0] wb, output logic [63:0] tgt, output logic wr,
      output logic ld, output logic mis);
    logic [63:0] m, a, r2, im, tg, b;
    logic lt, taken, is_br;
    int sh;
    m  = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
    a  = a_in & m; r2 = rs2_in & m; im = imm_in & m; tg = tag_in & m;
    is_br = (o >= 4'd9) && (o <= 4'd12);
    b  = (ivl && !is_br) ? im : r2;
    sh = (xl == 32) ? int'(b[4:0]) : int'(b[5:0]);
    lt = u ? (a < b) : ($signed(sx(xl, a)) < $signed(sx(xl, b)));
    wb = 64'd0; tgt = (tg + im) & m; taken = 1'b0;
    case (o)
      4'd0:  wb = a + b;
      4'd1:  wb = a - b;
      4'd2:  wb = a & b;
      4'd3:  wb = a | b;
      4'd4:  wb = a ^ b;
      4'd5:  wb = a << sh;
      4'd6:  wb = a >> sh;
      4'd7:  wb = $signed(sx(xl, a)) >>> sh;
      4'd8:  wb = {63'b0, lt};
      4'd9:  taken = (a == b);
      4'd10: taken = (a != b);
      4'd11: taken = lt;
      4'd12: taken = !lt;
      4'd13: begin wb = tg + 64'd4; taken = 1'b1; end
      4'd14: begin wb = tg + 64'd4; tgt = (a + im) & m & ~64'h1; taken = 1'b1; end
      default: ;
    endcase
    wb  = wb & m;
    wr  = rw && (r != 5'd0) && !is_br && (o != 4'd15);
    ld  = taken && !tgt[1];
    mis = taken && tgt[1];
  endfunction

  // Issue one op from a negedge, wait for its result and compare every field
  task automatic run_op(input bit w64, input string nm, input logic [3:0] o, input logic u,
      input logic [63:0] a, input logic [63:0] b, input logic [63:0] im, input logic ivl,
      input logic [63:0] tg, input logic [4:0] r, input logic rw);
    logic [63:0] e_wb, e_pc, bb;
    logic e_wr, e_ld, e_mis;
    int xl, sh, e_lat, lat, low;
    xl = w64 ? 64 : 32;
    model(xl, o, u, a, b, im, ivl, tg, r, rw, e_wb, e_pc, e_wr, e_ld, e_mis);
    bb = ivl ? im : b;
    sh = w64 ? int'(bb[5:0]) : int'(bb[4:0]);
    e_lat = (!w64 && (o >= 4'd5) && (o <= 4'd7) && sh != 0) ? sh + 1 : 1;
    op = o; unsign = u; rs1 = a; rs2 = b; imm = im; iv = ivl; tag = tg;
    rd = r; rd_wr = rw; flush = 1'b0;
    if (w64) v64 = 1'b1; else v32 = 1'b1;
    grab(w64);
    check({nm, "_ready"}, 64'(g_rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    lat = 1; low = 0;
    grab(w64);
    while (!g_ov && lat < 100) begin
      if (!g_rdy) low++;
      @(negedge clk);
      lat++;
      grab(w64);
    end
    check({nm, "_valid"}, 64'(g_ov), 64'd1);
    check({nm, "_latency"}, 64'(lat), 64'(e_lat));
    check({nm, "_busy_cycles"}, 64'(low), 64'(e_lat - 1));
    if (!((o >= 4'd9 && o <= 4'd12) || o == 4'd15)) check({nm, "_wb_data"}, g_wb, e_wb);
    check({nm, "_rd_addr"}, 64'(g_rd), 64'(r));
    check({nm, "_wr_en"}, 64'(g_wr), 64'(e_wr));
    check({nm, "_pc_load"}, 64'(g_ld), 64'(e_ld));
    check({nm, "_misalign"}, 64'(g_mis), 64'(e_mis));
    if (o >= 4'd9 && o <= 4'd14) check({nm, "_pc_out"}, g_pc, e_pc);
    @(negedge clk);
    grab(w64);
    check({nm, "_pulse_end"}, 64'({g_ov, g_wr}), 64'd0);
  endtask

  task automatic watch_quiet(input bit w64, input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      grab(w64);
      if (g_ov) seen++;
    end
    check(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [63:0] r_a, r_b, r_im, r_tg;
    rst = 1'b1; flush = 1'b0; v32 = 1'b0; v64 = 1'b0; unsign = 1'b0; iv = 1'b0;
    rd_wr = 1'b0; op = 4'd0; rs1 = '0; rs2 = '0; imm = '0; tag = '0; rd = '0;
    repeat (3) @(negedge clk);
    grab(0);
    check("reset32_outputs", {g_rdy, g_ov, g_wr, g_ld, g_mis, g_rd, g_wb[31:0], g_pc[31:0]}, 64'd0);
    grab(1);
    check("reset64_ready", 64'(g_rdy), 64'd0);
    check("reset64_outputs", g_wb | g_pc | 64'({g_ov, g_wr, g_ld, g_mis, g_rd}), 64'd0);
    rst = 1'b0;
    #1;
    grab(0);
    check("ready_after_reset", 64'(g_rdy), 64'd1);
    @(negedge clk);

    run_op(0, "add_ovf", 4'd0, 0, 64'h7FFF_FFFF, 64'd1, 64'd0, 0, 64'h0, 5'd1, 1);
    check("add_ovf_value", g_wb, 64'h8000_0000);
    run_op(0, "slt_signed", 4'd8, 0, 64'h7FFF_FFFF, 64'd1, 64'd0, 0, 64'h0, 5'd2, 1);
    run_op(0, "sltu_max", 4'd8, 1, 64'hFFFF_FFFF, 64'd1, 64'd0, 0, 64'h0, 5'd3, 1);
    run_op(0, "sra_serial4", 4'd7, 0, 64'h8000_0000, 64'd0, 64'd4, 1, 64'h0, 5'd4, 1);
    check("sra_serial4_value", g_wb, 64'hF800_0000);
    run_op(0, "sll_shamt0", 4'd5, 0, 64'h1234_5678, 64'd0, 64'd0, 1, 64'h0, 5'd5, 1);
    run_op(0, "bltu_taken", 4'd11, 1, 64'd1, 64'hFFFF_FFFF, 64'h20, 1, 64'h100, 5'd6, 1);
    check("bltu_taken_pc", g_pc, 64'h120);
    run_op(0, "jalr_x0", 4'd14, 0, 64'h1001, 64'd0, 64'd0, 1, 64'h200, 5'd0, 1);
    check("jalr_x0_link", g_wb, 64'h204);
    run_op(0, "jal_misalign", 4'd13, 0, 64'd0, 64'd0, 64'h6, 1, 64'h100, 5'd1, 1);
    run_op(0, "nop", 4'd15, 0, 64'd5, 64'd6, 64'd0, 0, 64'h40, 5'd7, 1);

    // Flush while idle blocks the offered op
    op = 4'd0; rs1 = 64'd3; rs2 = 64'd4; iv = 1'b0; rd = 5'd9; rd_wr = 1'b1;
    v32 = 1'b1; flush = 1'b1;
    #1; grab(0);
    check("flush_idle_ready", 64'(g_rdy), 64'd0);
    @(negedge clk);
    v32 = 1'b0; flush = 1'b0;
    grab(0);
    check("flush_idle_no_result", 64'(g_ov), 64'd0);

    // Flush during a 10-bit serial shift
    op = 4'd5; rs1 = 64'd1; imm = 64'd10; iv = 1'b1; rd = 5'd8; rd_wr = 1'b1; v32 = 1'b1;
    @(posedge clk); @(negedge clk);
    v32 = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1; grab(0);
    check("flush_shift_busy", 64'(g_rdy), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1; grab(0);
    check("flush_shift_ready_next", 64'(g_rdy), 64'd1);
    run_op(0, "add_after_flush", 4'd0, 0, 64'd10, 64'd20, 64'd0, 0, 64'h0, 5'd10, 1);
    watch_quiet(0, "flush_shift_no_result", 12);

    // Flush coinciding with the final shift step
    op = 4'd5; rs1 = 64'd1; imm = 64'd2; iv = 1'b1; rd = 5'd11; v32 = 1'b1;
    @(posedge clk); @(negedge clk);
    v32 = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    grab(0);
    check("flush_final_no_result", 64'(g_ov), 64'd0);
    watch_quiet(0, "flush_final_quiet", 4);

    // 64-bit directed
    run_op(1, "sll64_63", 4'd5, 0, 64'd1, 64'd63, 64'd0, 0, 64'h0, 5'd12, 1);
    check("sll64_63_value", g_wb, 64'h8000_0000_0000_0000);
    run_op(1, "sra64", 4'd7, 0, 64'h8000_0000_0000_0000, 64'd0, 64'd8, 1, 64'h0, 5'd13, 1);
    run_op(1, "bge64", 4'd12, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h40, 0, 64'h1000, 5'd1, 1);

    // Reset asserted mid-shift
    run_op(0, "jal_pre_reset", 4'd13, 0, 64'd0, 64'd0, 64'h40, 1, 64'h300, 5'd1, 1);
    op = 4'd5; rs1 = 64'd1; imm = 64'd20; iv = 1'b1; rd = 5'd14; v32 = 1'b1;
    @(posedge clk); @(negedge clk);
    v32 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 grab(0);
    check("reset_mid_shift", {g_rdy, g_ov, g_wr, g_ld, g_mis, g_rd, g_wb[31:0], g_pc[31:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 grab(0);
    check("reset_mid_shift_idle", 64'(g_rdy), 64'd1);
    watch_quiet(0, "reset_mid_shift_quiet", 25);

    // Random ops on both widths
    for (int i = 0; i < 60; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = {$urandom, $urandom};
      r_b  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r_b = r_a;
      r_im = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom};
      r_tg = {$urandom, $urandom} & ~64'h3;
      run_op(i >= 30, $sformatf("rand%0d_op%0d", i, r_op), r_op, 1'($urandom_range(0, 1)),
             r_a, r_b, r_im, 1'($urandom_range(0, 1)), r_tg, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
